// File: rtl/lifo_stream_reader.sv
// LIFO drain engine: pops a counted (or until-empty) burst from a
// show-ahead LIFO into a 2-entry skid buffer feeding a valid/ready stream.
module lifo_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   lifo_empty_i,
  input  logic [DATA_WIDTH-1:0]  pop_data_i,
  output logic                   pop_o,
  input  logic                   cmd_valid_i,
  input  logic [COUNT_WIDTH-1:0] cmd_count_i,
  output logic                   cmd_ready_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] drained_o,
  output logic                   underrun_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  b0_q, b0_d;
  logic [DATA_WIDTH-1:0]  b1_q, b1_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] drn_q, drn_d;
  logic                   unr_q, unr_d;
  logic                   cnt0_q, cnt0_d;

  logic pop;
  logic xfer;
  logic rdy;
  logic done;

  assign pop = (state_q == DRAIN) & ~lifo_empty_i
             & (occ_q != 2'd2)
             & ((rem_q != '0) | cnt0_q);
  assign xfer = (occ_q != 2'd0) & m_ready_i;

  // Reset masks the strobes combinationally so nothing leaks out
  // during the cycle reset is first sampled.
  assign pop_o       = pop & ~reset_i;
  assign m_valid_o   = (occ_q != 2'd0) & ~reset_i;
  assign m_data_o    = b0_q;
  assign done_o      = done & ~reset_i;
  assign cmd_ready_o = rdy & ~reset_i;
  assign drained_o   = drn_q;
  assign underrun_o  = unr_q;

  always_comb begin
    occ_d = occ_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    unique case ({pop, xfer})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) b0_d = pop_data_i;
        else               b1_d = pop_data_i;
      end
      2'b01: begin
        occ_d = occ_q - 2'd1;
        b0_d  = b1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          b0_d = pop_data_i;
        end else begin
          b0_d = b1_q;
          b1_d = pop_data_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt0_d  = cnt0_q;
    drn_d   = drn_q;
    unr_d   = unr_q;
    rdy     = 1'b0;
    done    = 1'b0;
    if (xfer && (drn_q != '1)) drn_d = drn_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (cmd_valid_i) begin
          rem_d   = cmd_count_i;
          cnt0_d  = (cmd_count_i == '0);
          drn_d   = '0;
          unr_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          if (!cnt0_q) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == {{(COUNT_WIDTH-1){1'b0}}, 1'b1})
              state_d = FLUSH;
          end
        end else if (lifo_empty_i) begin
          state_d = FLUSH;
          if (!cnt0_q && (rem_q != '0)) unr_d = 1'b1;
        end
      end
      FLUSH: begin
        if (occ_q == 2'd0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      b0_q    <= '0;
      b1_q    <= '0;
      rem_q   <= '0;
      drn_q   <= '0;
      unr_q   <= 1'b0;
      cnt0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      rem_q   <= rem_d;
      drn_q   <= drn_d;
      unr_q   <= unr_d;
      cnt0_q  <= cnt0_d;
    end
  end

endmodule

// File: tb/tb_lifo_stream_reader.sv
// Bench for lifo_stream_reader: 32-deep show-ahead LIFO model plus
// a stack-based reference of the expected beat stream.
module tb_lifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lifo_empty;
  logic [31:0] pop_data;
  logic        pop_o;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_count = 6'd0;
  logic        cmd_ready;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        done_o;
  logic [5:0]  drained;
  logic        underrun;

  logic        push_en = 1'b0;
  logic [31:0] push_data = 32'd0;
  logic [31:0] mem [32];
  logic [5:0]  sp = 6'd0;
  logic [5:0]  top;

  int rdy_mode = 1;
  int cyc = 0;
  int pops = 0;
  int outst = 0;
  int ovf = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int unstable = 0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_d = 32'd0;
  logic [31:0] got [$];
  int          gotcyc [$];
  logic [31:0] ref_stk [$];

  int checks = 0;
  int errors = 0;

  lifo_stream_reader dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .lifo_empty_i(lifo_empty),
    .pop_data_i  (pop_data),
    .pop_o       (pop_o),
    .cmd_valid_i (cmd_valid),
    .cmd_count_i (cmd_count),
    .cmd_ready_o (cmd_ready),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .done_o      (done_o),
    .drained_o   (drained),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  assign top        = sp - 6'd1;
  assign lifo_empty = (sp == 6'd0);
  assign pop_data   = (sp == 6'd0) ? 32'd0 : mem[top[4:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (push_en && sp < 6'd32) begin
      mem[sp[4:0]] <= push_data;
      sp <= sp + 6'd1;
    end else if (pop_o && sp != 6'd0) begin
      sp <= sp - 6'd1;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      2: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      outst <= 0;
    end else begin
      if (pop_o) pops <= pops + 1;
      if (pop_o && outst >= 2) ovf <= ovf + 1;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        gotcyc.push_back(cyc);
      end
      outst <= outst + (pop_o ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    if (stall_q && m_valid && m_data !== stall_d) unstable <= unstable + 1;
    stall_q <= m_valid && !m_ready && !reset;
    stall_d <= m_data;
  end

  task automatic push(input logic [31:0] v);
    push_en = 1'b1;
    push_data = v;
    ref_stk.push_back(v);
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic issue_cmd(input logic [5:0] c, output int base,
                           output int dbase, output int acc,
                           output logic rdy);
    cmd_valid = 1'b1;
    cmd_count = c;
    @(negedge clk);
    rdy = cmd_ready;
    base = got.size();
    dbase = done_cnt;
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int dbase, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt != dbase) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({pop_o, m_valid, done_o} !== 3'b000) begin
        errors++;
        $display("FAIL rst_outs got %b exp 000", {pop_o, m_valid, done_o});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || drained !== 6'd0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got rdy=%b drn=%0d unr=%b exp 1 0 0",
               cmd_ready, drained, underrun);
    end
    @(posedge clk); #1;
  endtask

  // Count mode: n beats expected, taken from the top of the reference stack.
  task automatic run_and_check(input string nm, input logic [5:0] c,
                               output int base, output int acc);
    int n, dbase;
    logic rdy, ok, exp_unr;
    logic [31:0] exp [$];
    exp_unr = (c != 0) && (int'(c) > ref_stk.size());
    n = (c == 0 || int'(c) > ref_stk.size()) ? ref_stk.size() : int'(c);
    for (int i = 0; i < n; i++) exp.push_back(ref_stk.pop_back());
    issue_cmd(c, base, dbase, acc, rdy);
    wait_done(dbase, ok);
    checks++;
    if (!rdy || !ok) begin
      errors++;
      $display("FAIL %s_handshake got rdy=%b done=%b exp 1 1", nm, rdy, ok);
    end
    checks++;
    if (got.size() - base != n) begin
      errors++;
      $display("FAIL %s_beats got %0d exp %0d", nm, got.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got[base+i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_data[%0d] got %h exp %h", nm, i, got[base+i], exp[i]);
        end
      end
    end
    checks++;
    if (drained !== 6'(n) || underrun !== exp_unr) begin
      errors++;
      $display("FAIL %s_status got drn=%0d unr=%b exp %0d %b",
               nm, drained, underrun, n, exp_unr);
    end
    checks++;
    if (int'(sp) != ref_stk.size() || ovf != 0) begin
      errors++;
      $display("FAIL %s_lifo got sp=%0d ovf=%0d exp %0d 0",
               nm, sp, ovf, ref_stk.size());
    end
    @(posedge clk); #1;
    checks++;
    if (done_cnt != dbase + 1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_pulse got cnt=%0d rdy=%b exp %0d 1",
               nm, done_cnt - dbase, cmd_ready, 1);
    end
  endtask

  task automatic test_count;
    int base, acc;
    rdy_mode = 1;
    for (int i = 1; i <= 8; i++) push(32'(i));
    run_and_check("cnt5", 6'd5, base, acc);
    checks++;
    if (gotcyc.size() >= base + 5 && gotcyc[base+4] - gotcyc[base] != 4) begin
      errors++;
      $display("FAIL cnt5_rate got span %0d exp 4", gotcyc[base+4] - gotcyc[base]);
    end
    run_and_check("rest", 6'd0, base, acc);
  endtask

  task automatic test_underrun;
    int base, acc;
    rdy_mode = 1;
    for (int i = 1; i <= 3; i++) push(32'(i));
    run_and_check("unr10", 6'd10, base, acc);
    checks++;
    if (lifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL unr10_empty got %b exp 1", lifo_empty);
    end
  endtask

  task automatic test_full_toggle;
    int base, acc;
    rdy_mode = 1;
    for (int i = 0; i < 32; i++) push($urandom);
    rdy_mode = 2;
    run_and_check("full", 6'd0, base, acc);
    rdy_mode = 1;
  endtask

  task automatic test_empty_cmd;
    int base, acc;
    run_and_check("empty4", 6'd4, base, acc);
    checks++;
    if (done_cyc - acc != 3) begin
      errors++;
      $display("FAIL empty4_latency got %0d exp 3", done_cyc - acc);
    end
  endtask

  task automatic test_stall;
    int base, dbase, acc;
    logic rdy, ok;
    push(32'hFFFF_FFFF);
    push(32'hFFFF_FFF6);
    rdy_mode = 0;
    @(posedge clk); #1;
    issue_cmd(6'd0, base, dbase, acc, rdy);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hFFFF_FFF6) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h exp 1 fffffff6",
                 i, m_valid, m_data);
      end
    end
    rdy_mode = 1;
    wait_done(dbase, ok);
    checks++;
    if (!ok || got.size() - base != 2 || unstable != 0) begin
      errors++;
      $display("FAIL stall_done got ok=%b beats=%0d unst=%0d exp 1 2 0",
               ok, got.size() - base, unstable);
    end else begin
      checks++;
      if (got[base] !== 32'hFFFF_FFF6 || got[base+1] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL stall_order got %h %h exp fffffff6 ffffffff",
                 got[base], got[base+1]);
      end
    end
    void'(ref_stk.pop_back());
    void'(ref_stk.pop_back());
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int base, dbase, acc, pbase, npop;
    logic rdy;
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) push($urandom);
    pbase = pops;
    issue_cmd(6'd20, base, dbase, acc, rdy);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || pop_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outs got v=%b pop=%b exp 0 0", m_valid, pop_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || m_valid !== 1'b0 || drained !== 6'd0) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b v=%b drn=%0d exp 1 0 0",
               cmd_ready, m_valid, drained);
    end
    npop = pops - pbase;
    for (int i = 0; i < npop; i++) void'(ref_stk.pop_back());
    @(posedge clk); #1;
    run_and_check("after_rst", 6'd0, base, acc);
  endtask

  task automatic test_random;
    int base, acc, k;
    logic [5:0] c;
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(0, 12);
      if (k > 32 - ref_stk.size()) k = 32 - ref_stk.size();
      rdy_mode = 1;
      for (int i = 0; i < k; i++) push($urandom);
      c = 6'($urandom_range(0, 12));
      rdy_mode = 3;
      run_and_check("rand", c, base, acc);
    end
    rdy_mode = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_count;
    test_underrun;
    test_full_toggle;
    test_empty_cmd;
    test_stall;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
